// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Scans an 8-entry hex buffer one digit per slot with per-slot anti-ghost blanking.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [7:0] blank_mask,
  output logic [7:0] out_dis,
  output logic [6:0] out_num,
  output logic       frame_tick
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam logic [DivW-1:0] DivLast  = DivW'(SCAN_DIV - 1);
  localparam logic [DivW-1:0] BlankCyc = DivW'(BLANK_CYC);

  logic [3:0]      digit_q [8];
  logic [2:0]      idx_q, idx_d;
  logic [DivW-1:0] div_q, div_d;
  logic            wrap_q, wrap_d;
  logic [7:0]      dis_q, dis_d;
  logic [6:0]      num_q, num_d;
  logic            tick_q;
  logic            slot_last;
  logic            blanked;
  logic [3:0]      cur_val;

  always_comb begin
    slot_last = (div_q == DivLast);
    div_d     = slot_last ? '0 : div_q + DivW'(1);
    idx_d     = slot_last ? idx_q + 3'd1 : idx_q;
    wrap_d    = slot_last && (idx_q == 3'd7);
  end

  // Outputs are computed from the state currently held and registered at the next edge.
  always_comb begin
    cur_val = digit_q[idx_q];
    blanked = (div_q < BlankCyc) || blank_mask[idx_q];
    dis_d   = blanked ? 8'hFF : ~(8'b1000_0000 >> idx_q);
    case (cur_val)
      4'h0:    num_d = 7'b0000001;
      4'h1:    num_d = 7'b1001111;
      4'h2:    num_d = 7'b0010010;
      4'h3:    num_d = 7'b0000110;
      4'h4:    num_d = 7'b1001100;
      4'h5:    num_d = 7'b0100100;
      4'h6:    num_d = 7'b0100000;
      4'h7:    num_d = 7'b0001111;
      4'h8:    num_d = 7'b0000000;
      4'h9:    num_d = 7'b0000100;
      4'hA:    num_d = 7'b0001000;
      4'hB:    num_d = 7'b1100000;
      4'hC:    num_d = 7'b0110001;
      4'hD:    num_d = 7'b1000010;
      4'hE:    num_d = 7'b0110000;
      default: num_d = 7'b0111000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) digit_q[i] <= 4'h0;
      idx_q  <= 3'd0;
      div_q  <= '0;
      wrap_q <= 1'b0;
      dis_q  <= 8'hFF;
      num_q  <= 7'b1111111;
      tick_q <= 1'b0;
    end else begin
      if (wr_en) digit_q[wr_addr] <= wr_data;
      idx_q  <= idx_d;
      div_q  <= div_d;
      wrap_q <= wrap_d;
      dis_q  <= dis_d;
      num_q  <= num_d;
      tick_q <= wrap_q;
    end
  end

  assign out_dis    = dis_q;
  assign out_num    = num_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed, table-driven bench for seg7_scan_driver with SCAN_DIV=8, BLANK_CYC=2.
module tb_seg7_scan_driver;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [7:0] blank_mask;
  logic [7:0] out_dis;
  logic [6:0] out_num;
  logic       frame_tick;

  int checks;
  int errors;
  int k;  // edges since reset release

  typedef struct {
    logic [3:0] val;
    logic [6:0] code;
  } dec_vec_t;

  dec_vec_t tbl [16];

  seg7_scan_driver #(
    .SCAN_DIV (8),
    .BLANK_CYC(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .blank_mask(blank_mask),
    .out_dis   (out_dis),
    .out_num   (out_num),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at k=%0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  // Expected anode pattern for the output seen after edge kk of the scan timeline.
  function automatic logic [7:0] exp_dis(input int kk, input logic [7:0] m);
    int s, slot, off;
    s    = kk - 1;
    slot = (s / 8) % 8;
    off  = s % 8;
    if (off < 2 || m[slot]) return 8'hFF;
    return ~(8'h80 >> slot);
  endfunction

  task automatic wait_k(input int target);
    for (int n = 0; n < 200; n++) begin
      if (k % 64 == target) return;
      step();
    end
    chk("wait_timeout", 32'(k % 64), 32'(target));
  endtask

  initial begin
    int ticks;
    tbl[0]  = '{4'h0, 7'b0000001}; tbl[1]  = '{4'h1, 7'b1001111};
    tbl[2]  = '{4'h2, 7'b0010010}; tbl[3]  = '{4'h3, 7'b0000110};
    tbl[4]  = '{4'h4, 7'b1001100}; tbl[5]  = '{4'h5, 7'b0100100};
    tbl[6]  = '{4'h6, 7'b0100000}; tbl[7]  = '{4'h7, 7'b0001111};
    tbl[8]  = '{4'h8, 7'b0000000}; tbl[9]  = '{4'h9, 7'b0000100};
    tbl[10] = '{4'hA, 7'b0001000}; tbl[11] = '{4'hB, 7'b1100000};
    tbl[12] = '{4'hC, 7'b0110001}; tbl[13] = '{4'hD, 7'b1000010};
    tbl[14] = '{4'hE, 7'b0110000}; tbl[15] = '{4'hF, 7'b0111000};

    checks = 0; errors = 0; k = 0;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; blank_mask = '0;

    // Reset values
    step(); step(); step();
    chk("rst_dis", 32'(out_dis), 32'h FF);
    chk("rst_num", 32'(out_num), 32'h7F);
    chk("rst_tick", 32'(frame_tick), 32'h0);
    rst_n = 1'b1;
    k = 0;
    step();
    chk("rel1_dis", 32'(out_dis), 32'hFF);
    step();
    chk("rel2_dis", 32'(out_dis), 32'hFF);
    step();
    chk("rel3_dis", 32'(out_dis), 32'h7F);
    chk("rel3_num", 32'(out_num), 32'(7'b0000001));

    // Full-frame scan with buffer = 0..7
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'(i);
      step();
    end
    wr_en = 1'b0;
    ticks = 0;
    for (int n = 0; n < 128; n++) begin
      step();
      chk("scan_dis", 32'(out_dis), 32'(exp_dis(k, 8'h00)));
      chk("scan_num", 32'(out_num), 32'(tbl[((k - 1) / 8) % 8].code));
      chk("scan_tick", 32'(frame_tick), 32'((k % 64 == 1) && (k > 1)));
      if (frame_tick) ticks++;
    end
    chk("tick_count", 32'(ticks), 32'd2);

    // Decode of every hex value on digit 0
    for (int i = 0; i < 16; i++) begin
      wait_k(56);
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = tbl[i].val;
      step();
      wr_en = 1'b0;
      wait_k(5);
      chk("dec_num", 32'(out_num), 32'(tbl[i].code));
      chk("dec_dis", 32'(out_dis), 32'h7F);
    end

    // Blank mask suppresses slots 2 and 5
    wait_k(0);
    blank_mask = 8'b0010_0100;
    for (int n = 0; n < 64; n++) begin
      step();
      chk("mask_dis", 32'(out_dis), 32'(exp_dis(k, 8'b0010_0100)));
    end
    blank_mask = 8'h00;

    // Live write to the digit being scanned
    wait_k(28);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'h9;
    step();
    wr_en = 1'b0;
    chk("live_old_num", 32'(out_num), 32'(7'b0000110));
    chk("live_old_dis", 32'(out_dis), 32'hEF);
    step();
    chk("live_new_num", 32'(out_num), 32'(7'b0000100));
    chk("live_new_dis", 32'(out_dis), 32'hEF);

    // Reset mid-scan (idx=5, div_cnt=4) with a concurrent write
    wait_k(44);
    rst_n = 1'b0; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'hF;
    step();
    chk("mrst_dis", 32'(out_dis), 32'hFF);
    chk("mrst_num", 32'(out_num), 32'h7F);
    chk("mrst_tick", 32'(frame_tick), 32'h0);
    rst_n = 1'b1; wr_en = 1'b0;
    k = 0;
    for (int n = 0; n < 72; n++) begin
      step();
      chk("post_dis", 32'(out_dis), 32'(exp_dis(k, 8'h00)));
      chk("post_num", 32'(out_num), 32'(7'b0000001));
      chk("post_tick", 32'(frame_tick), 32'(k == 65));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
